// File: rtl/raster_pkg.sv
// raster_pkg: shared state type and default widths for the raster scan counter
package raster_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} raster_state_t;
  localparam int COL_BITS_DEF  = 10;
  localparam int ROW_BITS_DEF  = 10;
  localparam int ADDR_BITS_DEF = 20;
endpackage

// File: rtl/axis_counter.sv
// axis_counter: wrap-to-zero counter for one raster axis with terminal detect
module axis_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         at_terminal
);
  assign at_terminal = count == terminal;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= at_terminal ? '0 : count + W'(1);
endmodule

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: raster-order pixel position and address generator
module raster_scan_counter
  import raster_pkg::*;
#(
  parameter int COL_BITS  = COL_BITS_DEF,
  parameter int ROW_BITS  = ROW_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 count_enable,
  input  logic                 wrap_mode,
  input  logic [COL_BITS-1:0]  num_cols,
  input  logic [ROW_BITS-1:0]  num_rows,
  input  logic [ADDR_BITS-1:0] frame_base,
  output logic [COL_BITS-1:0]  col_out,
  output logic [ROW_BITS-1:0]  row_out,
  output logic [ADDR_BITS-1:0] addr_out,
  output logic                 eol_flag,
  output logic                 eof_flag,
  output logic                 border_flag,
  output logic                 busy,
  output logic                 done
);
  raster_state_t        state;
  logic [COL_BITS-1:0]  cols_q;
  logic [ROW_BITS-1:0]  rows_q;
  logic [ADDR_BITS-1:0] base_q;
  logic                 wrap_q;
  logic                 col_term, row_term, go, step, last, stop;
  assign go   = start && state != RUN && num_cols != '0 && num_rows != '0;
  assign step = state == RUN && count_enable;
  assign last = col_term && row_term;
  // a non-wrapping frame parks on its last pixel instead of advancing
  assign stop = step && last && !wrap_q;
  axis_counter #(.W(COL_BITS)) u_col (
    .clk,
    .n_rst,
    .clear      (clear || go),
    .enable     (step && !stop),
    .terminal   (cols_q - COL_BITS'(1)),
    .count      (col_out),
    .at_terminal(col_term)
  );
  axis_counter #(.W(ROW_BITS)) u_row (
    .clk,
    .n_rst,
    .clear      (clear || go),
    .enable     (step && col_term && !stop),
    .terminal   (rows_q - ROW_BITS'(1)),
    .count      (row_out),
    .at_terminal(row_term)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state    <= IDLE;
      addr_out <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      base_q   <= '0;
      wrap_q   <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      addr_out <= '0;
    end else if (go) begin
      state    <= RUN;
      addr_out <= frame_base;
      cols_q   <= num_cols;
      rows_q   <= num_rows;
      base_q   <= frame_base;
      wrap_q   <= wrap_mode;
    end else if (step) begin
      state    <= stop ? DONE : RUN;
      addr_out <= stop ? addr_out : last ? base_q : addr_out + ADDR_BITS'(1);
    end
  assign busy        = state == RUN;
  assign done        = state == DONE;
  assign eol_flag    = busy && col_term;
  assign eof_flag    = eol_flag && row_term;
  assign border_flag = busy && (col_out == '0 || col_term || row_out == '0 || row_term);
endmodule

// File: tb/tb_raster_scan_counter.sv
// tb_raster_scan_counter: randomized self-checking bench against a pixel-index model
module tb_raster_scan_counter;
  logic        clk = 0, n_rst = 0, clear = 0, start = 0, count_enable = 0, wrap_mode = 0;
  logic [9:0]  num_cols = 0, num_rows = 0;
  logic [19:0] frame_base = 0;
  logic [9:0]  col_out, row_out;
  logic [19:0] addr_out;
  logic        eol_flag, eof_flag, border_flag, busy, done;
  logic [44:0] obs;
  int checks = 0, fails = 0;
  int m_state = 0, m_idx = 0, m_cols = 1, m_rows = 1, m_base = 0, m_wrap = 0;

  always #5 clk = ~clk;
  assign obs = {col_out, row_out, addr_out, eol_flag, eof_flag, border_flag, busy, done};

  raster_scan_counter dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .start(start), .count_enable(count_enable),
    .wrap_mode(wrap_mode), .num_cols(num_cols), .num_rows(num_rows), .frame_base(frame_base),
    .col_out(col_out), .row_out(row_out), .addr_out(addr_out), .eol_flag(eol_flag),
    .eof_flag(eof_flag), .border_flag(border_flag), .busy(busy), .done(done)
  );

  // expected outputs from the frame-level pixel index: col = idx % cols, row = idx / cols
  function automatic logic [44:0] model_vec();
    int c, r;
    logic b, e;
    c = 0;
    r = 0;
    if (m_state != 0) begin
      c = m_idx % m_cols;
      r = m_idx / m_cols;
    end
    b = m_state == 1;
    e = b && c == m_cols - 1;
    return {10'(c), 10'(r), m_state == 0 ? 20'd0 : 20'(m_base + r * m_cols + c),
            e, e && r == m_rows - 1,
            b && (c == 0 || c == m_cols - 1 || r == 0 || r == m_rows - 1),
            b, m_state == 2};
  endfunction

  task automatic cycle(input logic st, input logic cl, input logic en);
    start = st;
    clear = cl;
    count_enable = en;
    @(posedge clk);
    if (cl) begin
      m_state = 0;
      m_idx = 0;
    end else if (st && m_state != 1 && num_cols != 0 && num_rows != 0) begin
      m_state = 1;
      m_idx = 0;
      m_cols = int'(num_cols);
      m_rows = int'(num_rows);
      m_base = int'(frame_base);
      m_wrap = int'(wrap_mode);
    end else if (m_state == 1 && en) begin
      if (m_idx + 1 < m_cols * m_rows) m_idx++;
      else if (m_wrap != 0) m_idx = 0;
      else m_state = 2;
    end
    #1;
  endtask

  task automatic config_frame(input int c, input int r, input int b, input logic w);
    num_cols = 10'(c);
    num_rows = 10'(r);
    frame_base = 20'(b);
    wrap_mode = w;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 45'd0) begin
      fails++;
      $display("FAIL reset: got %h expected %h", obs, 45'd0);
    end
    n_rst = 1;
  endtask

  task automatic test_single_shot();
    config_frame(4, 3, 'h100, 1'b0);
    cycle(1, 0, 0);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (obs !== model_vec()) begin
        fails++;
        $display("FAIL single_shot step %0d: got %h expected %h", i, obs, model_vec());
      end
      cycle(0, 0, 1);
    end
    checks++;
    if (addr_out !== 20'h10B || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_shot_end: addr %h done %b busy %b expected 10b 1 0", addr_out, done, busy);
    end
  endtask

  task automatic test_wrap();
    config_frame(4, 3, 'h100, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 27; i++) begin
      checks++;
      if (obs !== model_vec() || done !== 1'b0) begin
        fails++;
        $display("FAIL wrap step %0d: got %h expected %h", i, obs, model_vec());
      end
      cycle(0, 0, 1);
    end
  endtask

  task automatic test_gaps();
    cycle(0, 1, 0);
    config_frame(4, 3, 'h100, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      checks++;
      if (obs !== model_vec()) begin
        fails++;
        $display("FAIL gaps step %0d: got %h expected %h", i, obs, model_vec());
      end
      cycle(1'($urandom_range(0, 3) == 0), 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_clear();
    cycle(0, 1, 0);
    config_frame(4, 3, 'h100, 1'b0);
    cycle(1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    checks++;
    if (col_out !== 10'd2 || row_out !== 10'd1 || addr_out !== 20'h106) begin
      fails++;
      $display("FAIL clear_setup: got (%0d,%0d) %h expected (2,1) 106", col_out, row_out, addr_out);
    end
    cycle(1, 1, 1);
    checks++;
    if (obs !== 45'd0) begin
      fails++;
      $display("FAIL clear: got %h expected %h", obs, 45'd0);
    end
    config_frame(0, 3, 'h200, 1'b0);
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    checks++;
    if (obs !== 45'd0 || obs !== model_vec()) begin
      fails++;
      $display("FAIL zero_dim_start: got %h expected %h", obs, 45'd0);
    end
  endtask

  task automatic test_one_by_one();
    config_frame(1, 1, 'h3A, 1'b0);
    cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== model_vec()) begin
        fails++;
        $display("FAIL one_by_one step %0d: got %h expected %h", i, obs, model_vec());
      end
      cycle(i == 1, 0, 1);
    end
    config_frame(1, 1, 'h3A, 1'b1);
    cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1);
      checks++;
      if (obs !== model_vec() || {eol_flag, eof_flag, border_flag, busy} !== 4'hF) begin
        fails++;
        $display("FAIL one_by_one_wrap step %0d: got %h expected %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0);
    config_frame(4, 3, 'h100, 1'b0);
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    #2;
    n_rst = 0;
    #1;
    m_state = 0;
    m_idx = 0;
    checks++;
    if (obs !== 45'd0) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", obs, 45'd0);
    end
    n_rst = 1;
    config_frame(2, 2, 'hFFFFE, 1'b0);
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== model_vec()) begin
        fails++;
        $display("FAIL addr_wrap step %0d: got %h expected %h", i, obs, model_vec());
      end
      cycle(0, 0, 1);
    end
    checks++;
    if (addr_out !== 20'h00001 || done !== 1'b1) begin
      fails++;
      $display("FAIL addr_wrap_end: addr %h done %b expected 00001 1", addr_out, done);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_wrap();
    test_gaps();
    test_clear();
    test_one_by_one();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
